// File: rtl/bluetooth_tx.sv
// UART transmitter with a small byte FIFO for driving a Bluetooth module RX pin.
// Frame is 8N1 by default; define BT_TX_PARITY_EN to insert an even-parity bit after bit 7.
module bluetooth_tx #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [15:0] BitLast = 16'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

`ifdef BT_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e          state_q, state_d;
  logic [15:0]     timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      data_q, data_d;
  logic            tx_q, tx_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push, pop, bit_end;
  logic [7:0]      head;

  assign in_ready   = count_q < Depth;
  assign push       = in_valid & in_ready & ~rst;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign busy       = (state_q != StIdle) || (count_q != '0);
  assign tx         = tx_q;
  assign bit_end    = (timer_q == BitLast);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 16'd1;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      StIdle: begin
        timer_d   = '0;
        bit_idx_d = '0;
        tx_d      = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          data_d  = head;
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = StData;
          tx_d      = data_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef BT_TX_PARITY_EN
            state_d = StParity;
            tx_d    = ^data_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = data_q[bit_idx_q + 3'd1];
          end
        end
      end
`ifdef BT_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          timer_d = '0;
          // Chain straight into the next frame so queued bytes leave with no idle gap.
          if (count_q != '0) begin
            pop     = 1'b1;
            data_d  = head;
            state_d = StStart;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_bluetooth_tx.sv
// Self-checking bench for bluetooth_tx against a frame-level queue model.
module tb_bluetooth_tx;
  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
`ifdef BT_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, tx, busy;
  logic [7:0] in_data;
  logic [2:0] fifo_count;

  int n_vec = 0;
  int n_err = 0;

  bluetooth_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Model: queued bytes plus the bit pattern and cycle position of the frame on the line.
  logic [7:0]  q[$];
  bit          m_active = 0;
  int          m_cyc = 0;
  logic [10:0] m_bits = '1;
  bit          m_acc = 0;

  function automatic logic exp_tx();
    return m_active ? m_bits[m_cyc / CPB] : 1'b1;
  endfunction
  function automatic logic exp_busy();
    return m_active || (q.size() != 0);
  endfunction
  function automatic logic exp_ready();
    return q.size() < DEPTH;
  endfunction
  function automatic logic [2:0] exp_count();
    return 3'(q.size());
  endfunction

  task automatic tick(input logic r, input logic v, input logic [7:0] d);
    bit ready_pre, start;
    logic [7:0] b;
    rst = r; in_valid = v; in_data = d;
    ready_pre = q.size() < DEPTH;
    m_acc = 0;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_active = 0;
      m_cyc = 0;
    end else begin
      start = 0;
      if (!m_active) start = q.size() != 0;
      else begin
        m_cyc++;
        if (m_cyc == FL * CPB) begin
          m_active = 0;
          start = q.size() != 0;
        end
      end
      if (start) begin
        b = q.pop_front();
        m_bits = {2'b11, b, 1'b0};
`ifdef BT_TX_PARITY_EN
        m_bits[9] = ^b;
`endif
        m_cyc = 0;
        m_active = 1;
      end
      if (v && ready_pre) begin
        q.push_back(d);
        m_acc = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx got %b want 1", tx); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready); end
    n_vec++; if (fifo_count !== 3'd0) begin
      n_err++; $display("FAIL reset_count got %0d want 0", fifo_count);
    end
  endtask

  task automatic test_single_byte();
    tick(1'b0, 1'b1, 8'h55);
    n_vec++; if (fifo_count !== 3'd1) begin
      n_err++; $display("FAIL single_count got %0d want 1", fifo_count);
    end
    for (int i = 0; i < FL * CPB + 6; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      n_vec++; if (tx !== exp_tx()) begin
        n_err++; $display("FAIL single_tx cyc %0d got %b want %b", i, tx, exp_tx());
      end
      n_vec++; if (busy !== (i < FL * CPB)) begin
        n_err++; $display("FAIL single_busy cyc %0d got %b want %b", i, busy, i < FL * CPB);
      end
      if (i == 0) begin
        n_vec++; if (tx !== 1'b0) begin n_err++; $display("FAIL single_start got %b want 0", tx); end
      end
    end
  endtask

  task automatic test_back_pressure();
    int idx = 0;
    for (int i = 0; i < 6 * FL * CPB + 40; i++) begin
      tick(1'b0, idx < 6, 8'(idx + 1));
      if (m_acc) idx++;
      n_vec++; if (tx !== exp_tx()) begin
        n_err++; $display("FAIL bp_tx cyc %0d got %b want %b", i, tx, exp_tx());
      end
      n_vec++; if (in_ready !== exp_ready() || fifo_count !== exp_count()) begin
        n_err++; $display("FAIL bp_fifo cyc %0d got rdy %b cnt %0d want rdy %b cnt %0d",
                          i, in_ready, fifo_count, exp_ready(), exp_count());
      end
      if (i == 4) begin
        n_vec++; if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin
          n_err++; $display("FAIL bp_full got rdy %b cnt %0d want rdy 0 cnt 4", in_ready, fifo_count);
        end
      end
      n_vec++; if (busy !== exp_busy()) begin
        n_err++; $display("FAIL bp_busy cyc %0d got %b want %b", i, busy, exp_busy());
      end
      // Six frames back to back: line must stay busy until the last stop bit ends.
      if (i > 0 && i <= 6 * FL * CPB) begin
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_gap cyc %0d got busy %b want 1", i, busy); end
      end
    end
    n_vec++; if (idx != 6) begin n_err++; $display("FAIL bp_accepted got %0d want 6", idx); end
  endtask

  task automatic test_ignored_offer();
    logic [7:0] fill [5];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44; fill[4] = 8'h5A;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, fill[i]);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 8'hAA);
      n_vec++; if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL ignored_full cyc %0d got cnt %0d rdy %b want cnt 4 rdy 0", i, fifo_count, in_ready);
      end
    end
    for (int i = 0; i < 5 * FL * CPB + 10; i++) begin
      tick(1'b0, 1'b0, 8'hAA);
      n_vec++; if (tx !== exp_tx()) begin
        n_err++; $display("FAIL ignored_tx cyc %0d got %b want %b", i, tx, exp_tx());
      end
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignored_drain got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    tick(1'b0, 1'b1, 8'hA5);
    tick(1'b0, 1'b1, 8'h3C);
    tick(1'b0, 1'b1, 8'h96);
    // Advance into data bit 3 (frame bit 4).
    for (int i = 0; i < 40 && m_cyc != 4 * CPB + 1; i++) tick(1'b0, 1'b0, 8'h00);
    n_vec++; if (m_cyc != 4 * CPB + 1 || fifo_count !== 3'd2) begin
      n_err++; $display("FAIL midrst_setup got cyc %0d cnt %0d want cyc %0d cnt 2", m_cyc, fifo_count, 4 * CPB + 1);
    end
    tick(1'b1, 1'b1, 8'h77);
    n_vec++; if (tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL midrst_abort got tx %b cnt %0d busy %b want 1 0 0", tx, fifo_count, busy);
    end
    for (int i = 0; i < 3 * FL * CPB; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      n_vec++; if (tx !== 1'b1 || busy !== 1'b0) begin
        n_err++; $display("FAIL midrst_quiet cyc %0d got tx %b busy %b want 1 0", i, tx, busy);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] pb [2];
    pb[0] = 8'h07; pb[1] = 8'h03;
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 1'b1, pb[k]);
      for (int i = 0; i < FL * CPB + 4; i++) begin
        tick(1'b0, 1'b0, 8'h00);
        n_vec++; if (tx !== exp_tx() || busy !== exp_busy()) begin
          n_err++; $display("FAIL parity_%0h cyc %0d got tx %b busy %b want %b %b",
                            pb[k], i, tx, busy, exp_tx(), exp_busy());
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      tick(1'b0, $urandom_range(0, 3) == 0, 8'($urandom));
      n_vec++; if (tx !== exp_tx() || busy !== exp_busy()) begin
        n_err++; $display("FAIL rand_line cyc %0d got tx %b busy %b want %b %b", i, tx, busy, exp_tx(), exp_busy());
      end
      n_vec++; if (in_ready !== exp_ready() || fifo_count !== exp_count()) begin
        n_err++; $display("FAIL rand_fifo cyc %0d got rdy %b cnt %0d want rdy %b cnt %0d",
                          i, in_ready, fifo_count, exp_ready(), exp_count());
      end
    end
    for (int i = 0; i < (DEPTH + 1) * FL * CPB + 5; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      n_vec++; if (tx !== exp_tx() || busy !== exp_busy()) begin
        n_err++; $display("FAIL rand_drain cyc %0d got tx %b busy %b want %b %b", i, tx, busy, exp_tx(), exp_busy());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_pressure();
    test_ignored_offer();
    test_reset_mid_frame();
    test_parity();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
